mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter peripheral that responds to CPU load/store accesses in the data-memory IO window. It complements the switch/button input path with a serial output path. CPU stores push bytes into an 8-entry FIFO. A shift engine drains the FIFO onto the `tx` line as 8N1 frames, LSB first. CPU loads of the status word expose FIFO and engine state so firmware can poll before writing.

---
 rtl/mmio_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores feed a small TX FIFO which a
// shift engine drains onto tx as 8N1 frames, LSB first. STATUS exposes FIFO
// and engine state so firmware can poll before writing.
module mmio_uart_tx #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        addr_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [15:0]     baud_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            busy_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            ovf_q;

  logic            push_req, clr_req, fifo_full, fifo_empty, bit_end;
  logic            pop, push_ok, ovf_set;
  logic [31:0]     status;

  // Access decode and FIFO handshake; a pop frees a slot before a same-cycle push.
  always_comb begin
    push_req   = sel_i && wr_en_i && !addr_i;
    clr_req    = sel_i && wr_en_i && addr_i && wdata_i[3];
    fifo_full  = (count_q == DepthC);
    fifo_empty = (count_q == '0);
    bit_end    = (baud_q == '0);
    pop        = !fifo_empty &&
                 ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    push_ok    = push_req && (!fifo_full || pop);
    ovf_set    = push_req && fifo_full && !pop;
  end

  // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clr_req) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are only read after being written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Shift engine with registered tx; STOP chains straight into START when data waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            baud_q  <= BaudLast;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            baud_q  <= BaudLast;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= BaudLast;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              baud_q  <= BaudLast;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              tx_q    <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // busy lags the engine/FIFO state by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_q != StIdle) || !fifo_empty;
    end
  end

  // Load data: STATUS word on addr 1, TXDATA reads as zero, nothing when unselected.
  always_comb begin
    status      = '0;
    status[0]   = fifo_full;
    status[1]   = fifo_empty;
    status[2]   = (state_q != StIdle);
    status[3]   = ovf_q;
    status[8:4] = 5'(count_q);
    rdata_o     = '0;
    if (sel_i && rd_en_i && addr_i) rdata_o = status;
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle,
// a mid-bit sampling receiver, and directed literal expectations.
module tb_mmio_uart_tx;

  localparam int B        = 4;
  localparam int D        = 8;
  localparam int FrameLen = 10 * B;

  logic        clk = 1'b0;
  logic        rst_n, sel, addr, wr_en, rd_en;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        tx, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mmio_uart_tx #(
    .BAUD_DIV  (B),
    .FIFO_DEPTH(D)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sel_i  (sel),
    .addr_i (addr),
    .wr_en_i(wr_en),
    .rd_en_i(rd_en),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .tx_o   (tx),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of waiting bytes plus position inside the frame on the line.
  logic [7:0] m_q[$];
  int         m_pos;
  logic [7:0] m_cur;
  logic       m_ovf, m_busy;

  function automatic logic m_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / B;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (m_q.size() == D);
    s[1]   = (m_q.size() == 0);
    s[2]   = (m_pos >= 0);
    s[3]   = m_ovf;
    s[8:4] = 5'(m_q.size());
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pos  = -1;
      m_cur  = '0;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_busy = (m_pos >= 0) || (m_q.size() != 0);
      if ((m_q.size() != 0) && ((m_pos < 0) || (m_pos == FrameLen - 1))) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end else if (m_pos == FrameLen - 1) begin
        m_pos = -1;
      end else if (m_pos >= 0) begin
        m_pos++;
      end
      if (sel && wr_en && !addr) begin
        if (m_q.size() < D) m_q.push_back(wdata);
        else m_ovf = 1'b1;
      end else if (sel && wr_en && addr && wdata[3]) begin
        m_ovf = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, m_tx());
      check("busy", busy, m_busy);
      check("rdata", rdata, (sel && rd_en && addr) ? m_status() : 32'h0);
    end
  end

  // Mid-bit sampling receiver collecting the bytes seen on tx.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh;
  int         rx_st = -1;
  int         rx_k;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st = -1;
    end else if (rx_st < 0) begin
      if (tx == 1'b0) rx_st = 0;
    end else begin
      rx_st++;
      if (rx_st % B == B / 2) begin
        rx_k = rx_st / B;
        if (rx_k >= 1 && rx_k <= 8) begin
          rx_sh[rx_k-1] = tx;
        end else if (rx_k == 9) begin
          rx_q.push_back(rx_sh);
          rx_st = -1;
        end
      end
    end
  end

  // Applies one cycle of inputs; called and returns at negedge + 1.
  task automatic drive(input logic s, input logic w, input logic r, input logic a,
                       input logic [7:0] d);
    sel = s; wr_en = w; rd_en = r; addr = a; wdata = d;
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_status(output logic [31:0] v);
    sel = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = 1'b1;
    #1 v = rdata;
  endtask

  task automatic chk_rx(input string name, input logic [7:0] first, input int n);
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) check(name, rx_q[i], first + 8'(i));
  endtask

  logic [31:0] st;
  logic [9:0]  seq1;
  logic [19:0] seq2;
  bit          hit;

  initial begin
    sel = 0; addr = 0; wr_en = 0; rd_en = 0; wdata = 0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset then idle.
    nop(50);
    check("idle_tx", tx, 1'b1);
    check("idle_busy", busy, 1'b0);
    read_status(st);
    check("idle_status", st, 32'h0000_0002);

    // Single byte 0xA5: start edge two clocks after the write, then mid-bit samples.
    rx_q.delete();
    seq1 = 10'b1101001010;
    wr(1'b0, 8'hA5);
    check("lat_tx_high", tx, 1'b1);
    nop(1);
    check("lat_tx_start", tx, 1'b0);
    nop(B / 2);
    for (int i = 0; i < 10; i++) begin
      check("a5_bit", tx, seq1[i]);
      check("a5_busy", busy, 1'b1);
      nop(B);
    end
    check("a5_busy_after", busy, 1'b0);
    chk_rx("a5_rx", 8'hA5, 1);

    // Back-to-back 0x00 then 0xFF: 80 contiguous cycles, count 1 during frame 1.
    nop(5);
    rx_q.delete();
    seq2 = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    wr(1'b0, 8'h00);
    wr(1'b0, 8'hFF);
    read_status(st);
    check("b2b_status", st, 32'h0000_0014);
    nop(B / 2);
    for (int i = 0; i < 20; i++) begin
      check("b2b_bit", tx, seq2[i]);
      nop(B);
    end
    check("b2b_busy_after", busy, 1'b0);
    check("b2b_rx0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h00);
    check("b2b_rx1", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'hFF);

    // Overflow: ten writes, 0x0A dropped, then write-to-clear.
    nop(5);
    rx_q.delete();
    for (int i = 1; i <= 10; i++) wr(1'b0, 8'(i));
    read_status(st);
    check("ovf_status", st, 32'h0000_008D);
    wr(1'b1, 8'h00);
    read_status(st);
    check("ovf_noclear", st, 32'h0000_008D);
    wr(1'b1, 8'h08);
    read_status(st);
    check("ovf_cleared", st, 32'h0000_0085);
    nop(400);
    chk_rx("ovf_rx", 8'h01, 9);

    // Push on the exact cycle STOP pops from a full FIFO.
    rx_q.delete();
    for (int i = 0; i < 9; i++) wr(1'b0, 8'h10 + 8'(i));
    hit = 1'b0;
    for (int i = 0; i < 2 * FrameLen && !hit; i++) begin
      if (m_pos == FrameLen - 1) hit = 1'b1;
      else nop(1);
    end
    check("pp_reached_stop", hit, 1'b1);
    wr(1'b0, 8'h19);
    read_status(st);
    check("pp_status", st, 32'h0000_0085);
    nop(420);
    chk_rx("pp_rx", 8'h10, 10);

    // Reset during data bit 3 aborts the frame and empties the FIFO.
    rx_q.delete();
    wr(1'b0, 8'h00);
    wr(1'b0, 8'h00);
    nop(17);
    check("mid_tx_low", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    read_status(st);
    check("mid_rst_status", st, 32'h0000_0002);
    nop(3);
    rst_n = 1'b1;
    nop(50);
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_rx", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
